// File: rtl/add_tree_res_acc.sv
// Accumulates ACC_LEN consecutive adder-tree partial sums into one saturated result
// and buffers completed results in a small FWFT FIFO drained by a valid/ready handshake.
module add_tree_res_acc #(
  parameter int DATA_WDT   = 16,
  parameter int LEN_WDT    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [DATA_WDT-1:0] tree_res_word,
  input  logic                tree_res_val,
  input  logic [LEN_WDT-1:0]  acc_len,
  input  logic                acc_clr,
  output logic [DATA_WDT-1:0] out_word,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                acc_busy,
  output logic                acc_ovf,
  output logic                acc_sat
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Returns {clamped, value}: signed add one bit wider, then clamp to the output range.
  function automatic logic [DATA_WDT:0] sat_add(input logic [DATA_WDT-1:0] a,
                                                input logic [DATA_WDT-1:0] b);
    logic [DATA_WDT:0] ext;
    ext = {a[DATA_WDT-1], a} + {b[DATA_WDT-1], b};
    if (ext[DATA_WDT] != ext[DATA_WDT-1]) begin
      if (ext[DATA_WDT]) begin
        sat_add = {1'b1, 1'b1, {(DATA_WDT-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(DATA_WDT-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, ext[DATA_WDT-1:0]};
    end
  endfunction

  logic [LEN_WDT-1:0]  cnt_q, cnt_d;
  logic [LEN_WDT-1:0]  len_q, len_d;
  logic [DATA_WDT-1:0] acc_q, acc_d;
  logic                acc_sat_q, acc_sat_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic [DATA_WDT-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WDT-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WDT-1:0] out_word_q, out_word_d;

  logic                in_evt_s;
  logic                clr_evt_s;
  logic                pop_s;
  logic                push_s;
  logic                first_s;
  logic                last_s;
  logic                sat_hit_s;
  logic [LEN_WDT-1:0]  len_eff_s;
  logic [LEN_WDT-1:0]  grp_len_s;
  logic [DATA_WDT-1:0] sum_s;
  logic [DATA_WDT:0]   sat_res_s;
  logic                fifo_full_s;
  logic                wr_ok_s;

  // Event qualification, effective group length and the running sum for this partial.
  always_comb begin
    in_evt_s  = clk_en & tree_res_val & ~acc_clr;
    clr_evt_s = clk_en & acc_clr;
    pop_s     = clk_en & out_rdy & (fifo_cnt_q != {CNT_W{1'b0}});
    first_s   = (cnt_q == {LEN_WDT{1'b0}});
    len_eff_s = (acc_len == {LEN_WDT{1'b0}}) ? LEN_WDT'(1) : acc_len;
    grp_len_s = first_s ? len_eff_s : len_q;
    last_s    = (cnt_q == (grp_len_s - LEN_WDT'(1)));
    sat_res_s = sat_add(acc_q, tree_res_word);
    if (first_s) begin
      sum_s     = tree_res_word;
      sat_hit_s = 1'b0;
    end else begin
      sum_s     = sat_res_s[DATA_WDT-1:0];
      sat_hit_s = sat_res_s[DATA_WDT];
    end
  end

  // Group counter / accumulator next state; acc_clr takes priority over the input.
  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    push_s    = 1'b0;
    if (clr_evt_s) begin
      cnt_d = {LEN_WDT{1'b0}};
      acc_d = {DATA_WDT{1'b0}};
    end else if (in_evt_s) begin
      acc_sat_d = acc_sat_q | sat_hit_s;
      if (first_s) begin
        len_d = len_eff_s;
      end else begin
        len_d = len_q;
      end
      if (last_s) begin
        push_s = 1'b1;
        cnt_d  = {LEN_WDT{1'b0}};
        acc_d  = {DATA_WDT{1'b0}};
      end else begin
        cnt_d = cnt_q + LEN_WDT'(1);
        acc_d = sum_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIFO update; a full FIFO still accepts a push when the head is popped the same cycle.
  always_comb begin
    fifo_full_s = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    wr_ok_s     = push_s & (~fifo_full_s | pop_s);
    acc_ovf_d   = acc_ovf_q | (push_s & fifo_full_s & ~pop_s);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = sum_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + (wr_ok_s ? CNT_W'(1) : CNT_W'(0)) - (pop_s ? CNT_W'(1) : CNT_W'(0));
  end

  // Registered head: follows the next head entry, holds the last word once empty.
  always_comb begin
    if (fifo_cnt_d != {CNT_W{1'b0}}) begin
      out_word_d = mem_d[rd_ptr_d];
    end else begin
      out_word_d = out_word_q;
    end
  end

  // State registers; clk_en low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {LEN_WDT{1'b0}};
      len_q      <= {LEN_WDT{1'b0}};
      acc_q      <= {DATA_WDT{1'b0}};
      acc_sat_q  <= 1'b0;
      acc_ovf_q  <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      fifo_cnt_q <= {CNT_W{1'b0}};
      out_word_q <= {DATA_WDT{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_WDT{1'b0}};
      end
    end else if (clk_en) begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
      acc_ovf_q  <= acc_ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_word_q <= out_word_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_word = out_word_q;
  assign out_val  = (fifo_cnt_q != {CNT_W{1'b0}});
  assign acc_busy = (cnt_q != {LEN_WDT{1'b0}});
  assign acc_ovf  = acc_ovf_q;
  assign acc_sat  = acc_sat_q;

endmodule

// File: tb/tb_add_tree_res_acc.sv
// Directed, table-driven bench for add_tree_res_acc plus hand-written reset sequences.
module tb_add_tree_res_acc;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic [15:0]        tree_res_word;
  logic               tree_res_val;
  logic [7:0]         acc_len;
  logic               acc_clr;
  logic [15:0]        out_word;
  logic               out_val;
  logic               out_rdy;
  logic               acc_busy;
  logic               acc_ovf;
  logic               acc_sat;

  int n_chk  = 0;
  int n_fail = 0;

  add_tree_res_acc #(.DATA_WDT(16), .LEN_WDT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .tree_res_word(tree_res_word), .tree_res_val(tree_res_val),
    .acc_len(acc_len), .acc_clr(acc_clr),
    .out_word(out_word), .out_val(out_val), .out_rdy(out_rdy),
    .acc_busy(acc_busy), .acc_ovf(acc_ovf), .acc_sat(acc_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en; logic val; int word; int len; logic clr; logic rdy;
    logic e_val; int e_word; logic e_busy; logic e_ovf; logic e_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic val, int word, int len, logic clr, logic rdy,
                              logic e_val, int e_word, logic e_busy, logic e_ovf, logic e_sat);
    vec_t v;
    v.en = en; v.val = val; v.word = word; v.len = len; v.clr = clr; v.rdy = rdy;
    v.e_val = e_val; v.e_word = e_word; v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_sat = e_sat;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input int w, input logic b,
                         input logic o, input logic s);
    chk({tag, "_val"},  int'(out_val),  int'(v));
    chk({tag, "_word"}, int'($signed(out_word)), w);
    chk({tag, "_busy"}, int'(acc_busy), int'(b));
    chk({tag, "_ovf"},  int'(acc_ovf),  int'(o));
    chk({tag, "_sat"},  int'(acc_sat),  int'(s));
  endtask

  task automatic drive(input logic en, input logic val, input int word, input int len,
                       input logic clr, input logic rdy);
    clk_en        = en;
    tree_res_val  = val;
    tree_res_word = 16'(word);
    acc_len       = 8'(len);
    acc_clr       = clr;
    out_rdy       = rdy;
  endtask

  initial begin
    // en val word len clr rdy | e_val e_word busy ovf sat
    // length 3: 5 + -2 + 10
    vecs.push_back(mk(1,1,     5,3,0,1, 0,     0,1,0,0));
    vecs.push_back(mk(1,1,    -2,3,0,1, 0,     0,1,0,0));
    vecs.push_back(mk(1,1,    10,3,0,1, 1,    13,0,0,0));
    vecs.push_back(mk(1,0,     0,3,0,1, 0,    13,0,0,0));
    // length 0 behaves as 1
    vecs.push_back(mk(1,1,     7,0,0,1, 1,     7,0,0,0));
    vecs.push_back(mk(1,1,     8,0,0,1, 1,     8,0,0,0));
    vecs.push_back(mk(1,0,     0,0,0,1, 0,     8,0,0,0));
    // saturation both directions
    vecs.push_back(mk(1,1, 30000,2,0,1, 0,     8,1,0,0));
    vecs.push_back(mk(1,1, 10000,2,0,1, 1, 32767,0,0,1));
    vecs.push_back(mk(1,1,-30000,2,0,1, 0, 32767,1,0,1));
    vecs.push_back(mk(1,1,-10000,2,0,1, 1,-32768,0,0,1));
    vecs.push_back(mk(1,0,     0,2,0,1, 0,-32768,0,0,1));
    // fill with no ready, overflow, push+pop on full, drain
    vecs.push_back(mk(1,1,     1,1,0,0, 1,     1,0,0,1));
    vecs.push_back(mk(1,1,     2,1,0,0, 1,     1,0,0,1));
    vecs.push_back(mk(1,1,     3,1,0,0, 1,     1,0,0,1));
    vecs.push_back(mk(1,1,     4,1,0,0, 1,     1,0,0,1));
    vecs.push_back(mk(1,1,     5,1,0,0, 1,     1,0,1,1));
    vecs.push_back(mk(1,1,     6,1,0,0, 1,     1,0,1,1));
    vecs.push_back(mk(1,1,     7,1,0,1, 1,     2,0,1,1));
    vecs.push_back(mk(1,0,     0,1,0,1, 1,     3,0,1,1));
    vecs.push_back(mk(1,0,     0,1,0,1, 1,     4,0,1,1));
    vecs.push_back(mk(1,0,     0,1,0,1, 1,     7,0,1,1));
    vecs.push_back(mk(1,0,     0,1,0,1, 0,     7,0,1,1));
    // acc_clr wins over a simultaneous input
    vecs.push_back(mk(1,1,     1,4,0,1, 0,     7,1,1,1));
    vecs.push_back(mk(1,1,     2,4,0,1, 0,     7,1,1,1));
    vecs.push_back(mk(1,1,     3,4,1,1, 0,     7,0,1,1));
    vecs.push_back(mk(1,1,     4,4,0,1, 0,     7,1,1,1));
    vecs.push_back(mk(1,1,     4,4,0,1, 0,     7,1,1,1));
    vecs.push_back(mk(1,1,     4,4,0,1, 0,     7,1,1,1));
    vecs.push_back(mk(1,1,     4,4,0,1, 1,    16,0,1,1));
    vecs.push_back(mk(1,0,     0,4,0,1, 0,    16,0,1,1));
    // clk_en freeze mid-group (clr ignored too), length change mid-group ignored
    vecs.push_back(mk(1,1,     9,3,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(0,1,   100,1,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(0,1,   100,1,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(0,1,   100,1,1,1, 0,    16,1,1,1));
    vecs.push_back(mk(0,1,   100,1,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(0,1,   100,1,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(1,1,     1,1,0,1, 0,    16,1,1,1));
    vecs.push_back(mk(1,1,     1,1,0,1, 1,    11,0,1,1));
    // no pop while clk_en low
    vecs.push_back(mk(0,0,     0,1,0,1, 1,    11,0,1,1));
    vecs.push_back(mk(0,0,     0,1,0,1, 1,    11,0,1,1));
    vecs.push_back(mk(1,0,     0,1,0,1, 0,    11,0,1,1));

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].val, vecs[i].word, vecs[i].len, vecs[i].clr, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_val, vecs[i].e_word, vecs[i].e_busy,
              vecs[i].e_ovf, vecs[i].e_sat);
    end

    // Asynchronous reset while a group is open and the FIFO is draining
    drive(1'b1, 1'b1, 5, 1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 1'b1, 6, 1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 1'b1, 7, 1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 1'b1, 9, 4, 1'b0, 1'b1); @(posedge clk); #1;
    chk_all("predrain", 1'b1, 6, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 9, 4, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("held_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 1, 1'b0, 1'b1); @(posedge clk); #1;
    chk_all("post_rst_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 42, 1, 1'b0, 1'b0); @(posedge clk); #1;
    chk_all("post_rst_push", 1'b1, 42, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
